// File: rtl/plab5_mcore_mem_port_arbiter_if.sv
// Bus bundle for the memory port arbiter: N requester-side request/response
// channels and the single shared memory-side request/response channel.
interface plab5_mcore_mem_port_arbiter_if #(
    parameter int p_num_reqs     = 2,
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_data_nbits   = 32
);
    localparam int LEN_NBITS = $clog2(p_data_nbits / 8);
    localparam int RQ = 3 + p_opaque_nbits + p_addr_nbits + LEN_NBITS + p_data_nbits;
    localparam int RS = 3 + p_opaque_nbits + LEN_NBITS + p_data_nbits;

    logic [p_num_reqs*RQ-1:0] in_req_msg;
    logic [p_num_reqs-1:0]    in_req_val;
    logic [p_num_reqs-1:0]    in_req_rdy;

    logic [RQ-1:0]            out_req_msg;
    logic                     out_req_val;
    logic                     out_req_rdy;

    logic [RS-1:0]            in_resp_msg;
    logic                     in_resp_val;
    logic                     in_resp_rdy;

    logic [p_num_reqs*RS-1:0] out_resp_msg;
    logic [p_num_reqs-1:0]    out_resp_val;
    logic [p_num_reqs-1:0]    out_resp_rdy;

    // arbiter side
    modport slave (
        input  in_req_msg, in_req_val,
        output in_req_rdy,
        output out_req_msg, out_req_val,
        input  out_req_rdy,
        input  in_resp_msg, in_resp_val,
        output in_resp_rdy,
        output out_resp_msg, out_resp_val,
        input  out_resp_rdy
    );

    // requesters + memory side
    modport master (
        output in_req_msg, in_req_val,
        input  in_req_rdy,
        input  out_req_msg, out_req_val,
        output out_req_rdy,
        output in_resp_msg, in_resp_val,
        input  in_resp_rdy,
        input  out_resp_msg, out_resp_val,
        output out_resp_rdy
    );
endinterface

// File: rtl/plab5_mcore_mem_port_arbiter.sv
// Round-robin arbiter sharing one in-order memory port between requesters.
// The requester ID of every issued request is queued in a tracking FIFO so
// that each returning response is steered back to whoever is at the head.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | free arbitration, round-robin scan starting at prio
// HOLD  | downstream stalled a valid request; grant pinned to lock_id
module plab5_mcore_mem_port_arbiter #(
    parameter int p_num_reqs        = 2,
    parameter int p_opaque_nbits    = 8,
    parameter int p_addr_nbits      = 32,
    parameter int p_data_nbits      = 32,
    parameter int p_max_outstanding = 4
) (
    input  logic clk,
    input  logic reset,
    plab5_mcore_mem_port_arbiter_if.slave bus
);
    localparam int LEN_NBITS = $clog2(p_data_nbits / 8);
    localparam int RQ = 3 + p_opaque_nbits + p_addr_nbits + LEN_NBITS + p_data_nbits;
    localparam int RS = 3 + p_opaque_nbits + LEN_NBITS + p_data_nbits;
    localparam int IW = ($clog2(p_num_reqs) > 1) ? $clog2(p_num_reqs) : 1;
    localparam int PW = $clog2(p_max_outstanding);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   prio, prio_nxt;
    logic [IW-1:0]   lock_id, lock_id_nxt;

    logic [IW-1:0]   fifo_mem [p_max_outstanding];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;

    logic [IW-1:0]   scan_id;
    logic [IW-1:0]   winner;
    logic            win_val;
    logic [IW-1:0]   head;
    logic            full, empty;
    logic            req_fire, resp_fire;

    assign full  = (count == CW'(p_max_outstanding));
    assign empty = (count == '0);
    assign head  = fifo_mem[rd_ptr];

    // Round-robin scan: walk offsets from high to low so the requester
    // closest to prio is the last (and therefore winning) assignment.
    always_comb begin
        int idx;
        scan_id = prio;
        for (int k = p_num_reqs - 1; k >= 0; k--) begin
            idx = int'(prio) + k;
            if (idx >= p_num_reqs) idx = idx - p_num_reqs;
            if (bus.in_req_val[idx]) scan_id = IW'(idx);
        end
    end

    assign winner  = (state == HOLD) ? lock_id : scan_id;
    assign win_val = bus.in_req_val[winner];

    assign bus.out_req_val = win_val & ~full;
    assign req_fire        = bus.out_req_val & bus.out_req_rdy;

    // Request mux and one-hot ready back to the winner.
    always_comb begin
        bus.out_req_msg = '0;
        bus.in_req_rdy  = '0;
        for (int i = 0; i < p_num_reqs; i++) begin
            if (winner == IW'(i)) begin
                bus.out_req_msg   = bus.in_req_msg[i*RQ +: RQ];
                bus.in_req_rdy[i] = bus.out_req_rdy & ~full;
            end
        end
    end

    // Response steering to the requester at the FIFO head.
    always_comb begin
        bus.out_resp_val = '0;
        for (int i = 0; i < p_num_reqs; i++) begin
            if (head == IW'(i)) bus.out_resp_val[i] = bus.in_resp_val & ~empty;
        end
    end

    assign bus.in_resp_rdy  = bus.out_resp_rdy[head] & ~empty;
    assign bus.out_resp_msg = {p_num_reqs{bus.in_resp_msg}};
    assign resp_fire        = bus.in_resp_val & bus.in_resp_rdy;

    // Arbiter next state: pin the grant on a stall, rotate prio on a handshake.
    always_comb begin
        state_nxt   = state;
        prio_nxt    = prio;
        lock_id_nxt = lock_id;
        if (req_fire) begin
            prio_nxt = (winner == IW'(p_num_reqs - 1)) ? '0 : winner + 1'b1;
        end
        case (state)
            IDLE: begin
                if (bus.out_req_val && !bus.out_req_rdy) begin
                    state_nxt   = HOLD;
                    lock_id_nxt = winner;
                end
            end
            HOLD: begin
                if (req_fire) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Arbiter state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            prio    <= '0;
            lock_id <= '0;
        end else begin
            state   <= state_nxt;
            prio    <= prio_nxt;
            lock_id <= lock_id_nxt;
        end
    end

    // Tracking FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (req_fire)  wr_ptr <= wr_ptr + 1'b1;
            if (resp_fire) rd_ptr <= rd_ptr + 1'b1;
            case ({req_fire, resp_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Tracking FIFO storage; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (req_fire) fifo_mem[wr_ptr] <= winner;
    end

endmodule

// File: tb/tb_plab5_mcore_mem_port_arbiter.sv
// Bench for the memory port arbiter: a hand-computed cycle table, a
// reset-mid-stream sequence, then randomized traffic against a queue model.
module tb_plab5_mcore_mem_port_arbiter;
    localparam int N   = 2;
    localparam int O   = 8;
    localparam int A   = 32;
    localparam int D   = 32;
    localparam int M   = 4;
    localparam int LEN = $clog2(D / 8);
    localparam int RQ  = 3 + O + A + LEN + D;
    localparam int RS  = 3 + O + LEN + D;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    plab5_mcore_mem_port_arbiter_if #(
        .p_num_reqs(N), .p_opaque_nbits(O), .p_addr_nbits(A), .p_data_nbits(D)
    ) bus ();

    plab5_mcore_mem_port_arbiter #(
        .p_num_reqs(N), .p_opaque_nbits(O), .p_addr_nbits(A), .p_data_nbits(D),
        .p_max_outstanding(M)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] val;
        logic       ordy;
        logic       rsv;
        logic [1:0] rsrdy;
        logic       oval;
        logic [1:0] irdy;
        int         g;
        logic       irsrdy;
        logic [1:0] orsv;
    } vec_t;

    vec_t tbl[24];
    logic [RQ-1:0] reqm [N];

    // model state for the random phase
    int  q[$];
    int  m_prio;
    bit  m_lock;
    int  m_lock_id;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [RQ-1:0] rand_rq();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[RQ-1:0];
    endfunction

    function automatic logic [RS-1:0] rand_rs();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[RS-1:0];
    endfunction

    task automatic drive(input logic [1:0] val, input logic ordy, input logic rsv,
                         input logic [1:0] rsrdy);
        for (int i = 0; i < N; i++) bus.in_req_msg[i*RQ +: RQ] = reqm[i];
        bus.in_req_val   = val;
        bus.out_req_rdy  = ordy;
        bus.in_resp_val  = rsv;
        bus.in_resp_msg  = rand_rs();
        bus.out_resp_rdy = rsrdy;
    endtask

    task automatic chk_fixed(input string tag, input logic oval, input logic [1:0] irdy,
                             input int g, input logic irsrdy, input logic [1:0] orsv);
        chk({tag, "_out_req_val"}, 256'(bus.out_req_val), 256'(oval));
        chk({tag, "_in_req_rdy"}, 256'(bus.in_req_rdy), 256'(irdy));
        if (oval) chk({tag, "_out_req_msg"}, 256'(bus.out_req_msg), 256'(reqm[g]));
        chk({tag, "_in_resp_rdy"}, 256'(bus.in_resp_rdy), 256'(irsrdy));
        chk({tag, "_out_resp_val"}, 256'(bus.out_resp_val), 256'(orsv));
        chk({tag, "_out_resp_msg"}, 256'(bus.out_resp_msg), 256'({N{bus.in_resp_msg}}));
    endtask

    // Reference: spec rules over a queue of issued IDs. Returns which
    // requester (if any) completed a request handshake this cycle.
    task automatic model_cycle(output int fired_id);
        int  w;
        int  j;
        int  h;
        bit  hit;
        bit  efull;
        bit  eov;
        bit  eirs;
        logic [1:0] eirdy;
        logic [1:0] eorsv;
        w = 0;
        hit = 1'b0;
        fired_id = -1;
        if (m_lock) begin
            w   = m_lock_id;
            hit = bus.in_req_val[w];
        end else begin
            for (int k = 0; k < N; k++) begin
                j = (m_prio + k) % N;
                if (!hit && bus.in_req_val[j]) begin
                    w   = j;
                    hit = 1'b1;
                end
            end
        end
        efull = (q.size() == M);
        eov   = hit && !efull;
        chk("rand_out_req_val", 256'(bus.out_req_val), 256'(eov));
        if (hit) begin
            eirdy = (bus.out_req_rdy && !efull) ? 2'(1 << w) : 2'b00;
            chk("rand_in_req_rdy", 256'(bus.in_req_rdy), 256'(eirdy));
        end
        if (eov) chk("rand_out_req_msg", 256'(bus.out_req_msg), 256'(reqm[w]));
        if (q.size() > 0) begin
            h     = q[0];
            eorsv = bus.in_resp_val ? 2'(1 << h) : 2'b00;
            eirs  = bus.out_resp_rdy[h];
        end else begin
            eorsv = 2'b00;
            eirs  = 1'b0;
        end
        chk("rand_out_resp_val", 256'(bus.out_resp_val), 256'(eorsv));
        chk("rand_in_resp_rdy", 256'(bus.in_resp_rdy), 256'(eirs));
        chk("rand_out_resp_msg", 256'(bus.out_resp_msg), 256'({N{bus.in_resp_msg}}));
        if (bus.in_resp_val && eirs) void'(q.pop_front());
        if (eov && bus.out_req_rdy) begin
            q.push_back(w);
            m_prio   = (w + 1) % N;
            m_lock   = 1'b0;
            fired_id = w;
        end else if (eov) begin
            m_lock    = 1'b1;
            m_lock_id = w;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] rv;
        logic         rordy;
        logic         rrsv;
        logic [N-1:0] rrsrdy;
        int           fired;

        //             val    ordy  rsv   rsrdy  | oval irdy  g  irsrdy orsv
        tbl[0]  = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 2'b01, 0, 1'b0, 2'b00};
        tbl[1]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 2'b10, 1, 1'b1, 2'b01};
        tbl[2]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 2'b01, 0, 1'b1, 2'b10};
        tbl[3]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 2'b10, 1, 1'b1, 2'b01};
        tbl[4]  = '{2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 0, 1'b1, 2'b10};
        tbl[5]  = '{2'b10, 1'b0, 1'b0, 2'b11, 1'b1, 2'b00, 1, 1'b0, 2'b00};
        tbl[6]  = '{2'b11, 1'b0, 1'b0, 2'b11, 1'b1, 2'b00, 1, 1'b0, 2'b00};
        tbl[7]  = '{2'b11, 1'b0, 1'b0, 2'b11, 1'b1, 2'b00, 1, 1'b0, 2'b00};
        tbl[8]  = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 2'b10, 1, 1'b0, 2'b00};
        tbl[9]  = '{2'b01, 1'b1, 1'b0, 2'b11, 1'b1, 2'b01, 0, 1'b1, 2'b00};
        tbl[10] = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 2'b10, 1, 1'b1, 2'b00};
        tbl[11] = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 2'b01, 0, 1'b1, 2'b00};
        tbl[12] = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b0, 2'b00, 0, 1'b1, 2'b00};
        tbl[13] = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 0, 1'b1, 2'b10};
        tbl[14] = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 2'b10, 1, 1'b1, 2'b00};
        tbl[15] = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b0, 2'b00, 0, 1'b1, 2'b00};
        tbl[16] = '{2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 0, 1'b0, 2'b01};
        tbl[17] = '{2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 0, 1'b0, 2'b01};
        tbl[18] = '{2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 0, 1'b1, 2'b01};
        tbl[19] = '{2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 0, 1'b1, 2'b10};
        tbl[20] = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 2'b01, 0, 1'b1, 2'b01};
        tbl[21] = '{2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 0, 1'b1, 2'b10};
        tbl[22] = '{2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 0, 1'b1, 2'b01};
        tbl[23] = '{2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 0, 1'b0, 2'b00};

        for (int i = 0; i < N; i++) reqm[i] = rand_rq();

        // In reset: nothing routable, request path still follows valids.
        drive(2'b11, 1'b0, 1'b1, 2'b11);
        #3;
        chk("rst_in_resp_rdy", 256'(bus.in_resp_rdy), 256'(0));
        chk("rst_out_resp_val", 256'(bus.out_resp_val), 256'(0));
        chk("rst_out_req_val", 256'(bus.out_req_val), 256'(1));
        chk("rst_out_req_msg", 256'(bus.out_req_msg), 256'(reqm[0]));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int r = 0; r < 24; r++) begin
            drive(tbl[r].val, tbl[r].ordy, tbl[r].rsv, tbl[r].rsrdy);
            @(negedge clk);
            chk_fixed($sformatf("tbl%0d", r), tbl[r].oval, tbl[r].irdy, tbl[r].g,
                      tbl[r].irsrdy, tbl[r].orsv);
            @(posedge clk);
            #1;
        end

        // Reset mid-stream with two requests outstanding (prio is 1 here).
        drive(2'b11, 1'b1, 1'b0, 2'b11);
        @(negedge clk);
        chk_fixed("pre_rst_a", 1'b1, 2'b10, 1, 1'b0, 2'b00);
        @(posedge clk);
        #1;
        drive(2'b11, 1'b1, 1'b0, 2'b11);
        @(negedge clk);
        chk_fixed("pre_rst_b", 1'b1, 2'b01, 0, 1'b1, 2'b00);
        @(posedge clk);
        #1;
        drive(2'b11, 1'b1, 1'b1, 2'b11);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_in_resp_rdy", 256'(bus.in_resp_rdy), 256'(0));
        chk("mid_rst_out_resp_val", 256'(bus.out_resp_val), 256'(0));
        chk("mid_rst_out_req_msg", 256'(bus.out_req_msg), 256'(reqm[0]));
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_fixed("post_rst_a", 1'b1, 2'b01, 0, 1'b0, 2'b00);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_fixed("post_rst_b", 1'b1, 2'b10, 1, 1'b1, 2'b01);
        @(posedge clk);
        #1;

        // Randomized traffic against the queue model.
        reset = 1'b0;
        #2;
        reset = 1'b1;
        q.delete();
        m_prio    = 0;
        m_lock    = 1'b0;
        m_lock_id = 0;
        rv        = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!rv[i]) begin
                    rv[i]   = ($urandom_range(0, 3) != 0);
                    reqm[i] = rand_rq();
                end
            end
            rordy = ($urandom_range(0, 3) != 0);
            if (q.size() > 0) rrsv = ($urandom_range(0, 2) != 0);
            else              rrsv = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < N; i++) rrsrdy[i] = ($urandom_range(0, 3) != 0);
            drive(rv, rordy, rrsv, rrsrdy);
            @(negedge clk);
            model_cycle(fired);
            @(posedge clk);
            #1;
            if (fired >= 0) rv[fired] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
